simple_bus_arbiter: RTL
=======================

# simple_bus_arbiter

Two-master arbiter that shares the single slave port of the simple bus between requesters. It latches one master's transaction, drives it onto the slave side, and routes the slave response back to the granted master. A round-robin pointer guarantees fairness, and a bounded timeout guarantees that a silent slave never locks the bus. It sits between the master agents and the slave port of `simple_bus`.

## Interface
- `AW`, 8, address width
- `DW`, 8, data width
- `TIMEOUT`, 16, maximum XFER cycles waiting for `s_valid`; must be ≥ 2
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `m0_req` / `m1_req`  in  1  master request; level, held until the master's valid is seen
- `m0_rw` / `m1_rw`  in  1  1 = read, 0 = write
- `m0_addr` / `m1_addr`  in  AW  address
- `m0_wdata` / `m1_wdata`  in  DW  write data
- `m0_rdata` / `m1_rdata`  out  DW  registered read data
- `m0_valid` / `m1_valid`  out  1  one-cycle completion pulse
- `m0_err` / `m1_err`  out  1  timeout flag, qualified by that master's valid
- `s_req`  out  1  slave request
- `s_rw`  out  1  slave read/write
- `s_addr`  out  AW  slave address
- `s_wdata`  out  DW  slave write data
- `s_rdata`  in  DW  slave read data
- `s_valid`  in  1  slave completion
- `gnt`  out  2  one-hot owner; 00 when idle
- `busy`  out  1  high in XFER and DONE

## Operation
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values: every output is 0, state = IDLE, `last` = 1 (master 0 wins first), timeout counter = 0.
- FSM state IDLE:
  - Samples `m0_req` and `m1_req`.
  - One requester present: it wins.
  - Both present: the master not equal to `last` wins.
  - On a win: register `s_req`=1 and `s_rw`/`s_addr`/`s_wdata` from the winner, set `gnt`, clear the counter, go to XFER.
- FSM state XFER:
  - Slave outputs are held stable; master inputs are ignored.
  - `s_valid`=1: `s_req`<=0, `mX_rdata`<=`s_rdata` (for reads and writes), `mX_valid`<=1, `mX_err`<=0, go to DONE.
  - Otherwise, counter == TIMEOUT-1: `s_req`<=0, `mX_valid`<=1, `mX_err`<=1, `mX_rdata`<={DW{1'b1}}, go to DONE.
  - Otherwise: counter increments.
- FSM state DONE (one cycle):
  - Valid/err pulse is visible.
  - Requests are ignored.
  - Next edge: valid/err<=0, `gnt`<=0, `last`<=owner, go to IDLE.
- Only the granted master's rdata/valid/err ever change; the other master's outputs hold.

## Timing
- Request sampled at edge N → `s_req`, `gnt`, `busy` high after edge N.
- Earliest `s_valid` sampled at edge N+1 → `mX_valid` high for one cycle after edge N+1.
- IDLE re-entered after edge N+2.
- Minimum of 3 cycles per transaction; a queued second master is granted at edge N+3.
- Timeout: `mX_valid`/`err` rise after edge N+TIMEOUT.
- Boundary conditions:
  - `s_valid` on the same edge the timeout expires: success wins, err=0.
  - `s_valid` while in IDLE or DONE: ignored; no output changes.
  - Master drops req during XFER: the transaction still completes and valid still pulses.
  - Master must drop req during DONE. A req still high in IDLE is a new transaction.
  - Round robin: a single continuous requester is re-granted every 3 cycles, but a contending master is always served between two of its grants.
  - `rst_n` low mid-transaction: all outputs go to 0 immediately, without waiting for a clock edge; the pending transaction is dropped and no valid is generated.

## Test plan
- Write from master 0, slave `s_valid` one cycle after `s_req`: m0 write A5/37 → `s_addr`=A5, `s_wdata`=37, `s_rw`=0, `gnt`=01; `m0_valid` one-cycle pulse, `m0_err`=0; master 1 outputs unchanged.
- Read from master 1, addr 42, slave returns BE with `s_valid` → `m1_rdata`=BE, `m1_valid` one-cycle pulse, `gnt`=10, `busy` deasserts 2 cycles after the pulse edge sequence.
- Both masters request at the same edge after reset, each dropping req on its valid → master 0 is granted first; master 1 is granted 3 cycles later; `s_addr` follows each owner's address.
- Both masters hold req continuously for 4 transactions → grant order 0,1,0,1.
- Slave never asserts `s_valid` with TIMEOUT=16 → `m0_valid`=1, `m0_err`=1, `m0_rdata`=FF exactly 16 cycles after grant; `s_req` low. Variant: `s_valid` arrives on cycle 16 → err=0.
- `rst_n` pulsed low mid-XFER → `s_req`, `gnt`, `busy` go to 0 asynchronously; no valid. After release, a new request from master 0 is granted normally.

Source files
------------

// File: rtl/simple_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : simple_bus_arbiter
// Brief    : Two-master round-robin arbiter for the simple_bus slave port,
//            with a bounded slave-response timeout.
// Revision : 1.0 - initial release
// ============================================================================
module simple_bus_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_rw,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_valid,
  output logic          m0_err,
  input  logic          m1_req,
  input  logic          m1_rw,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_valid,
  output logic          m1_err,
  output logic          s_req,
  output logic          s_rw,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  input  logic [DW-1:0] s_rdata,
  input  logic          s_valid,
  output logic [1:0]    gnt,
  output logic          busy
);

  localparam int            CW        = $clog2(TIMEOUT);
  localparam logic [CW-1:0] C_CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          r_last;
  logic          r_owner;
  logic [CW-1:0] r_cnt;
  logic          w_any;
  logic          w_win;
  logic          w_expire;

  // On contention the master that was not served last wins.
  assign w_any    = m0_req | m1_req;
  assign w_win    = (m0_req & m1_req) ? ~r_last : m1_req;
  assign w_expire = (r_cnt == C_CNT_MAX);
  assign busy     = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_state_next = S_XFER;
      S_XFER:  if (s_valid || w_expire) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last   <= 1'b1;
      r_owner  <= 1'b0;
      r_cnt    <= '0;
      s_req    <= 1'b0;
      s_rw     <= 1'b0;
      s_addr   <= '0;
      s_wdata  <= '0;
      gnt      <= 2'b00;
      m0_rdata <= '0;
      m0_valid <= 1'b0;
      m0_err   <= 1'b0;
      m1_rdata <= '0;
      m1_valid <= 1'b0;
      m1_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            s_req   <= 1'b1;
            s_rw    <= w_win ? m1_rw    : m0_rw;
            s_addr  <= w_win ? m1_addr  : m0_addr;
            s_wdata <= w_win ? m1_wdata : m0_wdata;
            gnt     <= w_win ? 2'b10 : 2'b01;
            r_owner <= w_win;
            r_cnt   <= '0;
          end
        end
        S_XFER: begin
          // A response on the expiry cycle still counts as success.
          if (s_valid || w_expire) begin
            s_req <= 1'b0;
            if (r_owner) begin
              m1_valid <= 1'b1;
              m1_err   <= ~s_valid;
              m1_rdata <= s_valid ? s_rdata : {DW{1'b1}};
            end else begin
              m0_valid <= 1'b1;
              m0_err   <= ~s_valid;
              m0_rdata <= s_valid ? s_rdata : {DW{1'b1}};
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          gnt    <= 2'b00;
          r_last <= r_owner;
          if (r_owner) begin
            m1_valid <= 1'b0;
            m1_err   <= 1'b0;
          end else begin
            m0_valid <= 1'b0;
            m0_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
